re_flow_solve: RTL and testbench
================================

// Module: re_flow_solve
// PURPOSE
//  Consumer end of the k-gain path: takes the structure tensor, the regularisation gain k
//  produced by the k calculator, and the previous velocity estimate.
//  Solves the k-regularised 2x2 optical-flow system for a new (vx, vy) in one shared
//  serial divider. Feeds the velocity back to the k calculator and to the output stage.
// PARAMETERS
//  TENSOR_WIDTH  14                  width of each tensor element, k, vx, vy (signed)
//  FRAC_BITS     TENSOR_WIDTH/2      fractional bits of vx/vy (Q format)
//  NUM_W         4*TENSOR_WIDTH+8    internal numerator/divider width; also divider iteration count
// PORTS
//  clk        in   1                   clock, all state on rising edge
//  rst_n      in   1                   asynchronous active-low reset
//  in_valid   in   1                   input bundle valid
//  in_ready   out  1                   block can accept a bundle
//  tensors    in   6*TENSOR_WIDTH      {xx,xy,xt,yy,yt,tt}, xx in MSBs, tt in LSBs (tt unused), signed
//  k          in   TENSOR_WIDTH        regularisation gain, signed, treated as >=0 (negative -> 0)
//  vx_prev    in   TENSOR_WIDTH        previous vx, signed Q(FRAC_BITS)
//  vy_prev    in   TENSOR_WIDTH        previous vy, signed Q(FRAC_BITS)
//  out_valid  out  1                   result valid
//  out_ready  in   1                   downstream accepts result
//  vx         out  TENSOR_WIDTH        new vx, signed Q(FRAC_BITS)
//  vy         out  TENSOR_WIDTH        new vy, signed Q(FRAC_BITS)
//  singular   out  1                   det<=0; vx=vy=0 reported
//  saturated  out  1                   vx or vy clipped to signed range
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; vx=vy=0; singular=saturated=0.
//   Reset mid-operation discards the bundle in flight; no partial result is ever emitted.
//  Handshake: bundle accepted on edge with in_valid&in_ready; result consumed on out_valid&out_ready.
//   in_ready=1 only in IDLE. out_valid, vx, vy, flags stay stable until consumed.
//  FSM: IDLE -> MUL1 (1 cyc) -> MUL2 (1 cyc) -> DIV_X (NUM_W cyc) -> DIV_Y (NUM_W cyc) -> DONE.
//   DONE -> IDLE on out_ready. out_valid first high 2*NUM_W+3 edges after the accepting edge.
//   Next bundle accepted no earlier than the edge after DONE exits (no overlap).
//  Arithmetic (all signed, NUM_W bits, sign-extended, no internal overflow):
//   MUL1: a=xx+k; c=yy+k; b=xy; px=((k*vx_prev)>>>FRAC_BITS)-xt; py=((k*vy_prev)>>>FRAC_BITS)-yt.
//   MUL2: det=a*c-b*b; nx=c*px-b*py; ny=a*py-b*px.
//   Divide: vx=(nx<<FRAC_BITS)/det, vy=(ny<<FRAC_BITS)/det.
//    Restoring, 1 quotient bit/cycle on magnitudes; sign = sign(num) XOR sign(det).
//    Rounds toward zero.
//  det<=0: divisions skipped (state timing unchanged); vx=vy=0, singular=1, saturated=0.
//  Saturation: quotient > 2^(TENSOR_WIDTH-1)-1 -> max; < -2^(TENSOR_WIDTH-1) -> min.
//   saturated=1 if either clips.
//  Inputs sampled only on the accepting edge; later input changes have no effect.
// TESTING (TENSOR_WIDTH=14, FRAC_BITS=7, NUM_W=64)
//  1 basic: xx=yy=16,xy=0,xt=-32,yt=16,k=0,prev=0 -> vx=256,vy=-128,flags 0,
//    out_valid at edge 131 after accept.
//  2 regularised: tensors all 0,k=16,vx_prev=128,vy_prev=-64 -> vx=128,vy=-64 (prev reproduced).
//  3 singular: tensors all 0,k=0 -> vx=vy=0,singular=1,saturated=0, same latency.
//  4 saturation: xx=yy=1,xt=-8191,others 0,k=0 -> vx=8191,vy=0,saturated=1.
//  5 backpressure: out_ready=0 for 20 cycles after result -> out_valid/vx/vy held, in_ready=0;
//    out_ready=1 -> in_ready=1 next cycle.
//  6 reset: assert rst_n=0 during DIV_X -> out_valid=0,in_ready=1 immediately;
//    fresh bundle after release gives the correct result.

Source files
------------

// File: rtl/re_flow_solve_if.sv
// Handshake bundle between the k calculator / output stage and the flow solver.
// master drives the request side, slave is the solver.
interface re_flow_solve_if #(
    parameter int TENSOR_WIDTH = 14
);
    logic                        in_valid;
    logic                        in_ready;
    logic [6*TENSOR_WIDTH-1:0]   tensors;
    logic [TENSOR_WIDTH-1:0]     k;
    logic [TENSOR_WIDTH-1:0]     vx_prev;
    logic [TENSOR_WIDTH-1:0]     vy_prev;
    logic                        out_valid;
    logic                        out_ready;
    logic [TENSOR_WIDTH-1:0]     vx;
    logic [TENSOR_WIDTH-1:0]     vy;
    logic                        singular;
    logic                        saturated;

    modport master (
        output in_valid, tensors, k, vx_prev, vy_prev, out_ready,
        input  in_ready, out_valid, vx, vy, singular, saturated
    );

    modport slave (
        input  in_valid, tensors, k, vx_prev, vy_prev, out_ready,
        output in_ready, out_valid, vx, vy, singular, saturated
    );
endinterface

// File: rtl/re_flow_solve.sv
// k-regularised 2x2 optical-flow solver: two multiply stages feed one shared
// restoring divider that produces vx then vy, followed by a saturate/format cycle.
module re_flow_solve #(
    parameter int TENSOR_WIDTH = 14,
    parameter int FRAC_BITS    = TENSOR_WIDTH / 2,
    parameter int NUM_W        = 4 * TENSOR_WIDTH + 8
) (
    input  logic             clk,
    input  logic             rst_n,
    re_flow_solve_if.slave   bus
);
    localparam int TW = TENSOR_WIDTH;
    localparam int CW = $clog2(NUM_W);
    localparam logic [NUM_W-1:0] ONE_N   = {{(NUM_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_W-1:0] POS_LIM = {{(NUM_W-TW+1){1'b0}}, {(TW-1){1'b1}}};
    localparam logic [NUM_W-1:0] NEG_LIM = POS_LIM + ONE_N;
    localparam logic [TW-1:0]    POS_MAX = {1'b0, {(TW-1){1'b1}}};
    localparam logic [TW-1:0]    NEG_MIN = {1'b1, {(TW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL1  = 3'd1,
        S_MUL2  = 3'd2,
        S_DIV_X = 3'd3,
        S_DIV_Y = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    function automatic logic [NUM_W-1:0] mag_fn(input logic signed [NUM_W-1:0] v);
        logic [NUM_W-1:0] r;
        if (v[NUM_W-1]) r = ~v + ONE_N;
        else            r = v;
        return r;
    endfunction

    // Returns {clipped, value}: applies the quotient sign and clamps to TW bits.
    function automatic logic [TW:0] sat_fn(input logic neg, input logic [NUM_W-1:0] mag);
        logic [NUM_W-1:0] neg_mag;
        logic [TW:0]      r;
        neg_mag = ~mag + ONE_N;
        if (!neg) begin
            if (mag > POS_LIM) r = {1'b1, POS_MAX};
            else               r = {1'b0, mag[TW-1:0]};
        end else begin
            if (mag > NEG_LIM) r = {1'b1, NEG_MIN};
            else               r = {1'b0, neg_mag[TW-1:0]};
        end
        return r;
    endfunction

    state_t state_q, state_d;

    logic signed [TW-1:0]    xx_q, xy_q, xt_q, yy_q, yt_q, k_q, vxp_q, vyp_q;
    logic signed [NUM_W-1:0] a_q, b_q, c_q, px_q, py_q;
    logic signed [NUM_W-1:0] k_e_s, a_s, c_s, px_s, py_s;
    logic signed [NUM_W-1:0] det_s, nx_s, ny_s;
    logic [NUM_W-1:0]        rem_q, dvd_q, dsr_q, qx_q, ny_mag_q;
    logic [NUM_W:0]          rem_sh_s, diff_s;
    logic [NUM_W-1:0]        rem_n_s, dvd_n_s;
    logic                    qbit_s;
    logic [CW-1:0]           cnt_q;
    logic                    sing_q, negx_q, negy_q;
    logic                    in_ready_q, out_valid_q, sing_out_q, sat_out_q;
    logic [TW-1:0]           vx_q, vy_q;
    logic [TW:0]             fx_s, fy_s;
    logic                    accept_s, consume_s, last_s, div_step_s, fmt_s;
    logic                    unused_tt_s;

    assign unused_tt_s = ^bus.tensors[TW-1:0];

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.vx        = vx_q;
    assign bus.vy        = vy_q;
    assign bus.singular  = sing_out_q;
    assign bus.saturated = sat_out_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_s) state_d = S_MUL1; else state_d = S_IDLE;
            S_MUL1:  state_d = S_MUL2;
            S_MUL2:  state_d = S_DIV_X;
            S_DIV_X: if (last_s) state_d = S_DIV_Y; else state_d = S_DIV_X;
            S_DIV_Y: if (last_s) state_d = S_DONE;  else state_d = S_DIV_Y;
            S_DONE:  if (consume_s) state_d = S_IDLE; else state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM-decoded control strobes.
    always_comb begin
        accept_s   = bus.in_valid & in_ready_q;
        consume_s  = out_valid_q & bus.out_ready;
        last_s     = (cnt_q == CW'(NUM_W - 1));
        div_step_s = 1'b0;
        fmt_s      = 1'b0;
        case (state_q)
            S_DIV_X, S_DIV_Y: div_step_s = 1'b1;
            S_DONE:           fmt_s      = ~out_valid_q;
            default:          div_step_s = 1'b0;
        endcase
    end

    // Stage arithmetic; negative k is treated as zero gain.
    always_comb begin
        if (k_q[TW-1]) k_e_s = '0;
        else           k_e_s = NUM_W'(k_q);
        a_s   = NUM_W'(xx_q) + k_e_s;
        c_s   = NUM_W'(yy_q) + k_e_s;
        px_s  = ((k_e_s * NUM_W'(vxp_q)) >>> FRAC_BITS) - NUM_W'(xt_q);
        py_s  = ((k_e_s * NUM_W'(vyp_q)) >>> FRAC_BITS) - NUM_W'(yt_q);
        det_s = a_q * c_q - b_q * b_q;
        nx_s  = c_q * px_q - b_q * py_q;
        ny_s  = a_q * py_q - b_q * px_q;
    end

    // One restoring-division step on magnitudes; quotient bits shift into dvd.
    always_comb begin
        rem_sh_s = {rem_q, dvd_q[NUM_W-1]};
        diff_s   = rem_sh_s - {1'b0, dsr_q};
        qbit_s   = ~diff_s[NUM_W];
        if (qbit_s) rem_n_s = diff_s[NUM_W-1:0];
        else        rem_n_s = rem_sh_s[NUM_W-1:0];
        dvd_n_s  = {dvd_q[NUM_W-2:0], qbit_s};
        fx_s     = sat_fn(negx_q, qx_q);
        fy_s     = sat_fn(negy_q, dvd_q);
    end

    // Datapath registers: input capture, multiply stages and the shared divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {xx_q, xy_q, xt_q, yy_q, yt_q} <= '0;
            {k_q, vxp_q, vyp_q}            <= '0;
            {a_q, b_q, c_q, px_q, py_q}    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            qx_q     <= '0;
            ny_mag_q <= '0;
            cnt_q    <= '0;
            sing_q   <= 1'b0;
            negx_q   <= 1'b0;
            negy_q   <= 1'b0;
        end else begin
            if (accept_s) begin
                {xx_q, xy_q, xt_q, yy_q, yt_q} <= bus.tensors[6*TW-1:TW];
                k_q   <= bus.k;
                vxp_q <= bus.vx_prev;
                vyp_q <= bus.vy_prev;
            end
            if (state_q == S_MUL1) begin
                a_q  <= a_s;
                b_q  <= NUM_W'(xy_q);
                c_q  <= c_s;
                px_q <= px_s;
                py_q <= py_s;
            end
            if (state_q == S_MUL2) begin
                sing_q   <= det_s[NUM_W-1] | (det_s == '0);
                negx_q   <= nx_s[NUM_W-1] ^ det_s[NUM_W-1];
                negy_q   <= ny_s[NUM_W-1] ^ det_s[NUM_W-1];
                dsr_q    <= mag_fn(det_s);
                dvd_q    <= mag_fn(nx_s <<< FRAC_BITS);
                ny_mag_q <= mag_fn(ny_s <<< FRAC_BITS);
                rem_q    <= '0;
                cnt_q    <= '0;
            end else if (div_step_s) begin
                cnt_q <= cnt_q + CW'(1);
                // The x quotient is parked and the y numerator swapped in on the last x step.
                if (state_q == S_DIV_X && last_s) begin
                    qx_q  <= sing_q ? '0 : dvd_n_s;
                    dvd_q <= ny_mag_q;
                    rem_q <= '0;
                end else if (!sing_q) begin
                    dvd_q <= dvd_n_s;
                    rem_q <= rem_n_s;
                end else begin
                    dvd_q <= dvd_q;
                    rem_q <= rem_q;
                end
            end
        end
    end

    // Registered outputs and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            vx_q        <= '0;
            vy_q        <= '0;
            sing_out_q  <= 1'b0;
            sat_out_q   <= 1'b0;
        end else begin
            in_ready_q <= (state_d == S_IDLE);
            if (fmt_s) begin
                out_valid_q <= 1'b1;
                sing_out_q  <= sing_q;
                if (sing_q) begin
                    vx_q      <= '0;
                    vy_q      <= '0;
                    sat_out_q <= 1'b0;
                end else begin
                    vx_q      <= fx_s[TW-1:0];
                    vy_q      <= fy_s[TW-1:0];
                    sat_out_q <= fx_s[TW] | fy_s[TW];
                end
            end else if (consume_s) begin
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= out_valid_q;
            end
        end
    end
endmodule

// File: tb/tb_re_flow_solve.sv
// Directed bench for re_flow_solve: hand-computed vectors, latency, backpressure, reset.
module tb_re_flow_solve;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    re_flow_solve_if #(.TENSOR_WIDTH(14)) bus ();

    re_flow_solve #(.TENSOR_WIDTH(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [83:0] pk(input int xx, input int xy, input int xt,
                                       input int yy, input int yt);
        return {14'(xx), 14'(xy), 14'(xt), 14'(yy), 14'(yt), 14'd0};
    endfunction

    task automatic send(input logic [83:0] t, input int kk, input int vxp, input int vyp);
        int n = 0;
        while (!bus.in_ready && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.tensors  = t;
        bus.k        = 14'(kk);
        bus.vx_prev  = 14'(vxp);
        bus.vy_prev  = 14'(vyp);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.tensors  = {84{1'b1}};
        bus.k        = 14'h1abc;
        bus.vx_prev  = 14'h0f0f;
        bus.vy_prev  = 14'h3333;
    endtask

    task automatic run_case(input string nm, input logic [83:0] t, input int kk,
                            input int vxp, input int vyp, input int evx, input int evy,
                            input int esing, input int esat);
        int lat = 0;
        send(t, kk, vxp, vyp);
        do begin
            @(posedge clk); #1; lat++;
        end while (!bus.out_valid && lat < 400);
        chk({nm, "_latency"}, lat, 131);
        chk({nm, "_vx"}, int'($signed(bus.vx)), evx);
        chk({nm, "_vy"}, int'($signed(bus.vy)), evy);
        chk({nm, "_singular"}, int'(bus.singular), esing);
        chk({nm, "_saturated"}, int'(bus.saturated), esat);
        if (bus.out_ready) begin
            @(posedge clk); #1;
            chk({nm, "_consumed"}, int'(bus.out_valid), 0);
            chk({nm, "_in_ready"}, int'(bus.in_ready), 1);
        end
    endtask

    initial begin
        int held_bad;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.tensors   = '0;
        bus.k         = '0;
        bus.vx_prev   = '0;
        bus.vy_prev   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_vx", int'(bus.vx), 0);
        chk("rst_vy", int'(bus.vy), 0);
        chk("rst_flags", int'({bus.singular, bus.saturated}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_case("basic",   pk(16, 0, -32, 16, 16), 0,   0,   0,  256, -128, 0, 0);
        run_case("reg",     pk(0, 0, 0, 0, 0),      16, 128, -64, 128,  -64, 0, 0);
        run_case("sing",    pk(0, 0, 0, 0, 0),      0,   0,   0,    0,    0, 1, 0);
        run_case("detneg",  pk(1, 2, 5, 1, 7),      0,   0,   0,    0,    0, 1, 0);
        run_case("satpos",  pk(1, 0, -8191, 1, 0),  0,   0,   0, 8191,    0, 0, 1);
        run_case("satneg",  pk(1, 0, 8191, 1, 0),   0,   0,   0, -8192,   0, 0, 1);
        run_case("round",   pk(3, 0, 1, 3, -1),     0,   0,   0,  -42,   42, 0, 0);
        run_case("coupled", pk(4, 1, -3, 2, -1),    0,   0,   0,   91,   18, 0, 0);
        run_case("kneg",    pk(16, 0, -32, 16, 16), -5, 100, 100, 256, -128, 0, 0);

        // Result must hold steady while downstream stalls.
        bus.out_ready = 1'b0;
        run_case("bp", pk(16, 0, -32, 16, 16), 0, 0, 0, 256, -128, 0, 0);
        held_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.in_ready || $signed(bus.vx) != 14'sd256
                || $signed(bus.vy) != -14'sd128) held_bad++;
        end
        chk("bp_hold", held_bad, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_out_valid_drop", int'(bus.out_valid), 0);
        chk("bp_in_ready", int'(bus.in_ready), 1);

        // Reset landing in the x division discards the bundle.
        send(pk(1, 0, -8191, 1, 0), 0, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_case("postrst", pk(16, 0, -32, 16, 16), 0, 0, 0, 256, -128, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
